// File: rtl/y86_defs.sv
// ============================================================================
// Module : y86_defs
// Brief  : Shared Y86-64 encodings: icodes, status, ALU functions, conditions.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package y86_defs;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] STAT_AOK = 4'h1;
    localparam logic [3:0] STAT_HLT = 4'h2;
    localparam logic [3:0] STAT_ADR = 4'h3;
    localparam logic [3:0] STAT_INS = 4'h4;

    localparam logic [3:0] R_NONE   = 4'hF;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_XOR  = 2'b11;

    localparam logic [3:0] C_YES    = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    // Condition-code bit positions inside the {ZF,SF,OF} vector
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

endpackage

`default_nettype wire

// File: rtl/ALU_64.sv
// ============================================================================
// Module : ALU_64
// Brief  : 64-bit two's-complement ALU (add/sub/and/xor) with zero and overflow.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ALU_64
    import y86_defs::*;
(
    input  wire logic [63:0] i_a,
    input  wire logic [63:0] i_b,
    input  wire logic [1:0]  i_fun,
    output logic      [63:0] o_res,
    output logic             o_zf,
    output logic             o_of
);

    logic [63:0] w_res;
    logic        w_of;

    always_comb begin
        w_res = '0;
        w_of  = 1'b0;
        case (i_fun)
            ALU_ADD: begin
                w_res = i_a + i_b;
                w_of  = (i_a[63] == i_b[63]) && (w_res[63] != i_a[63]);
            end
            ALU_SUB: begin
                // res = a - b; overflow when operand signs differ and result sign flips
                w_res = i_a - i_b;
                w_of  = (i_a[63] != i_b[63]) && (w_res[63] != i_a[63]);
            end
            ALU_AND: w_res = i_a & i_b;
            default: w_res = i_a ^ i_b;
        endcase
    end

    assign o_res = w_res;
    assign o_zf  = (w_res == 64'd0);
    assign o_of  = w_of;

endmodule

`default_nettype wire

// File: rtl/y86_cond.sv
// ============================================================================
// Module : y86_cond
// Brief  : Combinational condition evaluation from {ZF,SF,OF} and ifun.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module y86_cond
    import y86_defs::*;
(
    input  wire logic [2:0] i_cc,
    input  wire logic [3:0] i_ifun,
    output logic            o_cnd
);

    logic w_zf;
    logic w_lt;

    assign w_zf = i_cc[CC_ZF];
    assign w_lt = i_cc[CC_SF] ^ i_cc[CC_OF];

    always_comb begin
        o_cnd = 1'b0;
        case (i_ifun)
            C_YES:   o_cnd = 1'b1;
            C_LE:    o_cnd = w_lt | w_zf;
            C_L:     o_cnd = w_lt;
            C_E:     o_cnd = w_zf;
            C_NE:    o_cnd = ~w_zf;
            C_GE:    o_cnd = ~w_lt;
            C_G:     o_cnd = ~w_lt & ~w_zf;
            default: o_cnd = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/y86_execute_stage.sv
// ============================================================================
// Module : y86_execute_stage
// Brief  : Y86-64 execute stage: ALU steering, CC register, Cnd, E/M register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module y86_execute_stage
    import y86_defs::*;
#(
    parameter int         W     = 64,
    parameter logic [3:0] RNONE = R_NONE
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic [3:0]   E_stat,
    input  wire logic [3:0]   E_icode,
    input  wire logic [3:0]   E_ifun,
    input  wire logic [W-1:0] E_valC,
    input  wire logic [W-1:0] E_valA,
    input  wire logic [W-1:0] E_valB,
    input  wire logic [3:0]   E_dstE,
    input  wire logic [3:0]   E_dstM,
    input  wire logic         M_bubble,
    input  wire logic         M_stall,
    input  wire logic         mw_exc,
    output logic      [W-1:0] e_valE,
    output logic      [3:0]   e_dstE,
    output logic      [3:0]   M_stat,
    output logic      [3:0]   M_icode,
    output logic              M_Cnd,
    output logic      [W-1:0] M_valE,
    output logic      [W-1:0] M_valA,
    output logic      [3:0]   M_dstE,
    output logic      [3:0]   M_dstM,
    output logic      [2:0]   cc
);

    localparam logic [W-1:0] c_POS8 = W'(8);
    localparam logic [W-1:0] c_NEG8 = ~W'(7);

    logic [W-1:0] w_alu_a;
    logic [W-1:0] w_alu_b;
    logic [1:0]   w_alu_fun;
    logic [W-1:0] w_alu_res;
    logic         w_alu_zf;
    logic         w_alu_of;
    logic         w_set_cc;
    logic         w_cnd;
    logic [3:0]   w_dst_e;

    logic [2:0]   r_cc;
    logic [3:0]   r_stat;
    logic [3:0]   r_icode;
    logic         r_cnd;
    logic [W-1:0] r_val_e;
    logic [W-1:0] r_val_a;
    logic [3:0]   r_dst_e;
    logic [3:0]   r_dst_m;

    always_comb begin
        w_alu_a = '0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:             w_alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_alu_a = E_valC;
            I_CALL, I_PUSHQ:             w_alu_a = c_NEG8;
            I_RET, I_POPQ:               w_alu_a = c_POS8;
            default:                     w_alu_a = '0;
        endcase
    end

    always_comb begin
        w_alu_b = '0;
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
            I_PUSHQ, I_RET, I_POPQ:      w_alu_b = E_valB;
            default:                     w_alu_b = '0;
        endcase
    end

    assign w_alu_fun = (E_icode == I_OPQ) ? E_ifun[1:0] : ALU_ADD;

    // Operand order is swapped so that subq yields valB - valA
    ALU_64 u_alu (
        .i_a   (w_alu_b),
        .i_b   (w_alu_a),
        .i_fun (w_alu_fun),
        .o_res (w_alu_res),
        .o_zf  (w_alu_zf),
        .o_of  (w_alu_of)
    );

    assign w_set_cc = (E_icode == I_OPQ) && !mw_exc && (E_stat == STAT_AOK);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cc <= CC_RESET;
        end else if (w_set_cc) begin
            r_cc <= {w_alu_zf, w_alu_res[W-1], w_alu_of};
        end
    end

    y86_cond u_cond (
        .i_cc   (r_cc),
        .i_ifun (E_ifun),
        .o_cnd  (w_cnd)
    );

    // A not-taken conditional move writes nowhere
    assign w_dst_e = ((E_icode == I_RRMOVQ) && !w_cnd) ? RNONE : E_dstE;

    always_ff @(posedge clk) begin
        if (rst || M_bubble) begin
            r_stat  <= STAT_AOK;
            r_icode <= I_NOP;
            r_cnd   <= 1'b0;
            r_val_e <= '0;
            r_val_a <= '0;
            r_dst_e <= RNONE;
            r_dst_m <= RNONE;
        end else if (!M_stall) begin
            r_stat  <= E_stat;
            r_icode <= E_icode;
            r_cnd   <= w_cnd;
            r_val_e <= w_alu_res;
            r_val_a <= E_valA;
            r_dst_e <= w_dst_e;
            r_dst_m <= E_dstM;
        end
    end

    assign e_valE  = w_alu_res;
    assign e_dstE  = w_dst_e;
    assign M_stat  = r_stat;
    assign M_icode = r_icode;
    assign M_Cnd   = r_cnd;
    assign M_valE  = r_val_e;
    assign M_valA  = r_val_a;
    assign M_dstE  = r_dst_e;
    assign M_dstM  = r_dst_m;
    assign cc      = r_cc;

endmodule

`default_nettype wire

// File: tb/tb_y86_execute_stage.sv
// ============================================================================
// Module : tb_y86_execute_stage
// Brief  : Directed plus random checks of the execute stage against a reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_y86_execute_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  E_stat = 4'h1, E_icode = 4'h1, E_ifun = 4'h0;
    logic [63:0] E_valC = '0, E_valA = '0, E_valB = '0;
    logic [3:0]  E_dstE = 4'hF, E_dstM = 4'hF;
    logic        M_bubble = 1'b0, M_stall = 1'b0, mw_exc = 1'b0;
    logic [63:0] e_valE, M_valE, M_valA;
    logic [3:0]  e_dstE, M_stat, M_icode, M_dstE, M_dstM;
    logic        M_Cnd;
    logic [2:0]  cc;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [2:0]  m_cc;
    logic [3:0]  x_stat, x_icode, x_dstE, x_dstM;
    logic        x_cnd;
    logic [63:0] x_valE, x_valA;

    y86_execute_stage #(.W(64), .RNONE(4'hF)) dut (
        .clk(clk), .rst(rst), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE),
        .E_dstM(E_dstM), .M_bubble(M_bubble), .M_stall(M_stall), .mw_exc(mw_exc),
        .e_valE(e_valE), .e_dstE(e_dstE), .M_stat(M_stat), .M_icode(M_icode),
        .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE),
        .M_dstM(M_dstM), .cc(cc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_cnd(input logic [2:0] c, input logic [3:0] f);
        logic zf, sf, of;
        zf = c[2]; sf = c[1]; of = c[0];
        case (f)
            4'd0: return 1'b1;
            4'd1: return (sf != of) || zf;
            4'd2: return sf != of;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return sf == of;
            4'd6: return (sf == of) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] ref_val(input logic [3:0] ic, input logic [3:0] f,
                                            input logic [63:0] c, input logic [63:0] a,
                                            input logic [63:0] b);
        case (ic)
            4'h2: return a;
            4'h3: return c;
            4'h4, 4'h5: return b + c;
            4'h6: case (f[1:0])
                2'd0: return b + a;
                2'd1: return b - a;
                2'd2: return b & a;
                default: return b ^ a;
            endcase
            4'h8, 4'hA: return b - 64'd8;
            4'h9, 4'hB: return b + 64'd8;
            default: return 64'd0;
        endcase
    endfunction

    // OPQ flags from signed arithmetic widened to 65 bits
    function automatic logic [2:0] ref_flags(input logic [3:0] f, input logic [63:0] a,
                                             input logic [63:0] b);
        logic signed [64:0] wide;
        logic [63:0] r;
        logic ovf;
        r = ref_val(4'h6, f, 64'd0, a, b);
        ovf = 1'b0;
        if (f[1:0] == 2'd0) begin
            wide = $signed({b[63], b}) + $signed({a[63], a});
            ovf = wide[64] != wide[63];
        end else if (f[1:0] == 2'd1) begin
            wide = $signed({b[63], b}) - $signed({a[63], a});
            ovf = wide[64] != wide[63];
        end
        return {r == 64'd0, r[63], ovf};
    endfunction

    task automatic step(input logic [3:0] st, input logic [3:0] ic, input logic [3:0] f,
                        input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic bub, input logic stl, input logic exc);
        logic        cnd;
        logic [63:0] v;
        logic [3:0]  d;
        E_stat = st; E_icode = ic; E_ifun = f; E_valC = c; E_valA = a; E_valB = b;
        E_dstE = de; E_dstM = dm; M_bubble = bub; M_stall = stl; mw_exc = exc;
        #1;
        cnd = ref_cnd(m_cc, f);
        v   = ref_val(ic, f, c, a, b);
        d   = (ic == 4'h2 && !cnd) ? 4'hF : de;
        if (!rst) begin
            chk("e_valE", e_valE, v);
            chk("e_dstE", {60'd0, e_dstE}, {60'd0, d});
        end
        @(posedge clk);
        #1;
        if (rst || bub) begin
            x_stat = 4'h1; x_icode = 4'h1; x_cnd = 1'b0; x_valE = '0; x_valA = '0;
            x_dstE = 4'hF; x_dstM = 4'hF;
        end else if (!stl) begin
            x_stat = st; x_icode = ic; x_cnd = cnd; x_valE = v; x_valA = a;
            x_dstE = d; x_dstM = dm;
        end
        if (rst) m_cc = 3'b100;
        else if (ic == 4'h6 && !exc && st == 4'h1) m_cc = ref_flags(f, a, b);
        chk("M_stat",  {60'd0, M_stat},  {60'd0, x_stat});
        chk("M_icode", {60'd0, M_icode}, {60'd0, x_icode});
        chk("M_Cnd",   {63'd0, M_Cnd},   {63'd0, x_cnd});
        chk("M_valE",  M_valE, x_valE);
        chk("M_valA",  M_valA, x_valA);
        chk("M_dstE",  {60'd0, M_dstE},  {60'd0, x_dstE});
        chk("M_dstM",  {60'd0, M_dstM},  {60'd0, x_dstM});
        chk("cc",      {61'd0, cc},      {61'd0, m_cc});
    endtask

    initial begin
        logic [3:0]  r_ic, r_f, r_st;
        logic [63:0] r_a, r_b, r_c;
        m_cc = 3'b100;
        x_stat = 4'h1; x_icode = 4'h1; x_cnd = 1'b0; x_valE = '0; x_valA = '0;
        x_dstE = 4'hF; x_dstM = 4'hF;

        // Reset state
        @(posedge clk);
        step(4'h1, 4'h6, 4'h0, 64'd0, 64'd11, 64'd22, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // subq 5-3, then 5-5
        step(4'h1, 4'h6, 4'h1, 64'd0, 64'd3, 64'd5, 4'h2, 4'hF, 1'b0, 1'b0, 1'b0);
        step(4'h1, 4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h2, 4'hF, 1'b0, 1'b0, 1'b0);

        // Positive overflow on addq, then jumps on the resulting flags
        step(4'h1, 4'h6, 4'h0, 64'd0, 64'h4000000000000000, 64'h4000000000000000,
             4'h4, 4'hF, 1'b0, 1'b0, 1'b0);
        step(4'h1, 4'h7, 4'h1, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
        step(4'h1, 4'h7, 4'h2, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
        step(4'h1, 4'h7, 4'h6, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);

        // cmovle with cc=100 (taken) and cc=000 (not taken)
        step(4'h1, 4'h6, 4'h1, 64'd0, 64'd9, 64'd9, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0);
        step(4'h1, 4'h2, 4'h1, 64'd0, 64'd7, 64'd0, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0);
        step(4'h1, 4'h6, 4'h1, 64'd0, 64'd1, 64'd9, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0);
        step(4'h1, 4'h2, 4'h1, 64'd0, 64'd7, 64'd0, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0);

        // Stack pointer adjust
        step(4'h1, 4'hA, 4'h0, 64'd0, 64'h55, 64'h100, 4'h4, 4'hF, 1'b0, 1'b0, 1'b0);
        step(4'h1, 4'hB, 4'h0, 64'd0, 64'h55, 64'h100, 4'h4, 4'h6, 1'b0, 1'b0, 1'b0);

        // Exception suppresses CC; stall holds; bubble beats stall; non-AOK stat
        step(4'h1, 4'h6, 4'h3, 64'd0, 64'h1234, 64'h1234, 4'h5, 4'hF, 1'b0, 1'b0, 1'b1);
        step(4'h1, 4'h3, 4'h0, 64'h77, 64'd1, 64'd2, 4'h7, 4'hF, 1'b0, 1'b1, 1'b0);
        step(4'h1, 4'h3, 4'h0, 64'h77, 64'd1, 64'd2, 4'h7, 4'hF, 1'b1, 1'b1, 1'b0);
        step(4'h3, 4'h6, 4'h1, 64'd0, 64'd2, 64'd2, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0);

        // Random stream
        for (int i = 0; i < 300; i++) begin
            r_ic = 4'($urandom_range(0, 11));
            r_f  = (r_ic == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 8));
            r_st = ($urandom_range(0, 9) < 8) ? 4'h1 : 4'($urandom_range(2, 4));
            r_a  = {$urandom, $urandom};
            r_b  = {$urandom, $urandom};
            r_c  = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: r_b = r_a;
                1: begin r_a = 64'h7FFFFFFFFFFFFFFF; r_b = {$urandom_range(0, 1) == 0, 63'd5}; end
                2: begin r_a = 64'h8000000000000000; r_b = {32'd0, $urandom}; end
                default: ;
            endcase
            step(r_st, r_ic, r_f, r_c, r_a, r_b, 4'($urandom), 4'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0);
        end

        // Reset mid-stream discards a valid load
        rst = 1'b1;
        step(4'h1, 4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(4'h1, 4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/y86_execute_stage.md
Name: y86_execute_stage

Overview:
- Execute stage of the pipelined Y86-64 processor.
- Takes E-register fields from decode and steers ALU operands and function into the existing 64-bit ALU (ALU_64).
- Owns the condition-code register and computes Cnd for jXX and cmovXX.
- Latches results into the E/M pipeline register for the memory stage. Also exposes the combinational e_valE and e_dstE for forwarding.

Parameters:
- W, 64, datapath width.
- RNONE, 4'hF, "no register" destination id.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- E_stat  in  4  status of instruction in E (AOK=1, HLT=2, ADR=3, INS=4)
- E_icode  in  4  instruction code
- E_ifun  in  4  function / condition code
- E_valC  in  W  constant word
- E_valA  in  W  operand A
- E_valB  in  W  operand B
- E_dstE  in  4  ALU result destination register
- E_dstM  in  4  memory result destination register
- M_bubble  in  1  load NOP bubble into E/M register this edge
- M_stall  in  1  hold E/M register contents
- mw_exc  in  1  excepting instruction in M or W (m_stat or W_stat not AOK); suppresses CC update
- e_valE  out  W  combinational ALU result (forwarding)
- e_dstE  out  4  combinational effective dstE (forwarding)
- M_stat  out  4  registered status
- M_icode  out  4  registered icode
- M_Cnd  out  1  registered condition result
- M_valE  out  W  registered ALU result
- M_valA  out  W  registered valA (store data / return address)
- M_dstE  out  4  registered dstE
- M_dstM  out  4  registered dstM
- cc  out  3  {ZF,SF,OF} condition codes

Behaviour:
- icodes:
  - HALT=0, NOP=1, RRMOVQ/CMOV=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5
  - OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B
- ALU encoding: 00 add, 01 sub, 10 and, 11 xor.
- aluA select:
  - RRMOVQ, OPQ: valA
  - IRMOVQ, RMMOVQ, MRMOVQ: valC
  - CALL, PUSHQ: -8
  - RET, POPQ: +8
  - else 0
- aluB select:
  - RMMOVQ, MRMOVQ, OPQ, CALL, PUSHQ, RET, POPQ: valB
  - RRMOVQ, IRMOVQ: 0
  - else 0
- ALU inputs: a=aluB, b=aluA, so subq computes valB-valA. Function = E_ifun[1:0] for OPQ, else add.
- e_valE is the ALU res.
- CC update:
  - set_cc = (E_icode==OPQ) && !mw_exc && (E_stat==AOK).
  - On a clk edge with set_cc: ZF=ALU zero, SF=res[W-1], OF=ALU overflow.
  - Otherwise CC holds.
- Cnd from current (pre-update) CC, by ifun:
  - 0 always 1
  - 1 le: (SF^OF)|ZF
  - 2 l: SF^OF
  - 3 e: ZF
  - 4 ne: !ZF
  - 5 ge: !(SF^OF)
  - 6 g: !(SF^OF)&!ZF
  - ifun>6: 0
- e_dstE = RNONE when E_icode==RRMOVQ and !Cnd; else E_dstE.
- E/M register priority per edge: rst > M_bubble > M_stall > load.
  - Load captures E_stat, E_icode, Cnd, e_valE, E_valA, e_dstE, E_dstM.
  - Stall holds all M_* outputs.
  - Bubble loads stat=AOK, icode=NOP, Cnd=0, valE=0, valA=0, dstE=dstM=RNONE.
  - M_bubble and M_stall both high: bubble wins.
- Reset (synchronous):
  - M_* take bubble values.
  - cc={1,0,0}.
  - Reset asserted mid-stream discards in-flight E/M contents the same edge.
- Latency: one cycle E to M_*. e_valE and e_dstE are purely combinational.
- Overflow and wrap-around follow ALU_64 two's-complement semantics. No saturation.
- Status: non-AOK E_stat propagates unchanged and never modifies CC.

Decomposition:
- Package y86_defs holds:
  - icode constants
  - stat codes
  - RNONE
  - ALU function encodings
  - condition ifun constants
- One sub-module, y86_cond: pure combinational (cc, ifun) -> Cnd. Reused by the stage and unit-tested alone.
- Instantiates the existing ALU_64 unchanged.

Test Plan:
- rst=1 one edge -> M_icode=1, M_stat=1, M_dstE=M_dstM=F, M_valE=0, cc=100.
- OPQ subq (ifun=1), valA=3, valB=5, dstE=2 -> e_valE=2; next edge M_valE=2, M_dstE=2, cc=000. Then valA=5, valB=5 -> cc=100.
- OPQ addq, valA=valB=0x4000000000000000 -> M_valE=0x8000000000000000, cc=011. Following JXX ifun=1 (le) -> M_Cnd=0; ifun=2 (l) -> M_Cnd=0; ifun=6 (g) -> M_Cnd=1.
- cmovle (icode=2, ifun=1) with cc=100, valA=7, dstE=3 -> e_dstE=3, M_valE=7. Same with cc=000 -> e_dstE=F, M_Cnd=0.
- PUSHQ valB=0x100 -> M_valE=0xF8. POPQ valB=0x100 -> M_valE=0x108. CC unchanged in both cases.
- OPQ xorq with mw_exc=1 -> cc unchanged, M_valE still computed. M_stall=1 -> M_* held. M_stall=1 and M_bubble=1 -> bubble values loaded.
